// File: rtl/latch_ctrl_pkg.sv
// Shared state encoding and default geometry for the latch-bank write controller.
package latch_ctrl_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DW     = 8;
    localparam int DEF_NWORD  = 4;
    localparam int DEF_EN_CYC = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
module rr_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    logic [IW:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(N_REQ)) begin
                idx = idx - (IW+1)'(N_REQ);
            end
            if (!valid && req[idx[IW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Arbitrates N_REQ writers onto a shared latch bank: data set up one cycle before
// a one-hot enable pulse of EN_CYC cycles, then held one cycle while ack is issued.
module latch_bank_arbiter
    import latch_ctrl_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DW     = DEF_DW,
    parameter int NWORD  = DEF_NWORD,
    parameter int EN_CYC = DEF_EN_CYC,
    localparam int AW    = (NWORD > 1) ? $clog2(NWORD) : 1,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] wdata,
    input  logic [N_REQ*AW-1:0] waddr,
    output logic [DW-1:0]       lat_d,
    output logic [NWORD-1:0]    lat_en,
    output logic [N_REQ-1:0]    ack,
    output logic                busy,
    output logic [IW-1:0]       gnt_id
);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [AW-1:0] addr;
    logic [2:0]    cnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .valid  (win_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            lat_d  <= '0;
            lat_en <= '0;
            ack    <= '0;
            busy   <= 1'b0;
            gnt_id <= '0;
            ptr    <= '0;
            addr   <= '0;
            cnt    <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    lat_en <= '0;
                    if (win_vld) begin
                        // Capture everything now; requester inputs are ignored until IDLE.
                        lat_d  <= wdata[int'(win)*DW +: DW];
                        addr   <= waddr[int'(win)*AW +: AW];
                        gnt_id <= win;
                        busy   <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    lat_en <= {{(NWORD-1){1'b0}}, 1'b1} << addr;
                    cnt    <= '0;
                    state  <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    if (cnt == 3'(EN_CYC-1)) begin
                        lat_en      <= '0;
                        ack[gnt_id] <= 1'b1;
                        ptr         <= (gnt_id == IW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_HOLD: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    lat_en <= '0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench with a completion scoreboard per DUT (EN_CYC=1 and EN_CYC=3).
module tb_latch_bank_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req,  req3;
    logic [31:0] wdata, wdata3;
    logic [7:0]  waddr, waddr3;
    logic [7:0]  lat_d, lat_d3;
    logic [3:0]  lat_en, lat_en3, ack, ack3;
    logic        busy, busy3;
    logic [1:0]  gnt_id, gnt_id3;

    exp_t q0[$], q1[$];
    int   n_vec = 0, n_err = 0;

    logic [3:0] p_en[2];
    logic [7:0] p_d[2];
    logic [1:0] en_addr[2];
    logic [7:0] en_data[2];
    int         run[2];
    logic       after_en[2];

    always #5 clk = ~clk;

    latch_bank_arbiter u_dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .waddr(waddr),
        .lat_d(lat_d), .lat_en(lat_en), .ack(ack), .busy(busy), .gnt_id(gnt_id)
    );

    latch_bank_arbiter #(.EN_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .wdata(wdata3), .waddr(waddr3),
        .lat_d(lat_d3), .lat_en(lat_en3), .ack(ack3), .busy(busy3), .gnt_id(gnt_id3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic mon(input int d, input logic [3:0] en, input logic [7:0] dd,
                       input logic [3:0] ak, input logic [1:0] gid, input logic bsy,
                       input int encyc);
        exp_t e;
        if (rst) begin
            p_en[d] = '0; p_d[d] = dd; run[d] = 0; after_en[d] = 1'b0;
            return;
        end
        check("onehot_or_zero", 32'($countones(en) <= 1), 1);
        if (p_en[d] != 0 || en != 0)
            check("lat_d_stable", dd, p_d[d]);
        if (en != 0) begin
            check("busy_during_en", bsy, 1);
            if (p_en[d] == 0) begin
                run[d] = 1;
                en_data[d] = dd;
                for (int i = 0; i < 4; i++) if (en[i]) en_addr[d] = 2'(i);
            end else begin
                run[d]++;
                check("en_steady", en, p_en[d]);
            end
        end
        after_en[d] = (p_en[d] != 0 && en == 0);
        if (ak != 0) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                check("unexpected_ack", ak, 0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check("ack_vec", ak, 32'(1) << e.id);
                check("ack_gnt_id", gid, e.id);
                check("lat_addr", en_addr[d], e.addr);
                check("lat_data", en_data[d], e.data);
                check("en_cycles", run[d], encyc);
                check("ack_after_en", after_en[d], 1);
                check("busy_in_hold", bsy, 1);
            end
        end
        p_en[d] = en;
        p_d[d]  = dd;
    endtask

    always @(negedge clk) begin
        mon(0, lat_en,  lat_d,  ack,  gnt_id,  busy,  1);
        mon(1, lat_en3, lat_d3, ack3, gnt_id3, busy3, 3);
    end

    task automatic wait_ack(input int budget, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ack == 0 && k < budget);
        if (ack == 0) check("ack_timeout", k, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int waited;
        rst = 1'b0; req = '0; wdata = '0; waddr = '0;
        req3 = '0; wdata3 = '0; waddr3 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_lat_d", lat_d, 0);
        check("rst_lat_en", lat_en, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_lat_en3", lat_en3, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Single request, EN_CYC=1
        @(negedge clk);
        req = 4'b0001; wdata[7:0] = 8'hA5; waddr[1:0] = 2'd2;
        q0.push_back('{id: 2'd0, addr: 2'd2, data: 8'hA5});
        @(negedge clk);
        check("setup_busy", busy, 1);
        check("setup_en", lat_en, 0);
        check("setup_d", lat_d, 8'hA5);
        check("setup_gnt", gnt_id, 0);
        @(negedge clk);
        check("enable_en", lat_en, 4'b0100);
        @(negedge clk);
        check("hold_ack", ack, 4'b0001);
        check("hold_en", lat_en, 0);
        req = '0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ack", ack, 0);

        // Four continuous requesters from ptr=0: order 0,1,2,3,0, one ack per 4 cycles
        reset_pulse();
        @(negedge clk);
        wdata = 32'h44332211; waddr = 8'b00_01_10_11; req = 4'b1111;
        q0.push_back('{id: 2'd0, addr: 2'd3, data: 8'h11});
        q0.push_back('{id: 2'd1, addr: 2'd2, data: 8'h22});
        q0.push_back('{id: 2'd2, addr: 2'd1, data: 8'h33});
        q0.push_back('{id: 2'd3, addr: 2'd0, data: 8'h44});
        q0.push_back('{id: 2'd0, addr: 2'd3, data: 8'h11});
        for (int i = 0; i < 5; i++) begin
            wait_ack(20, k);
            if (i > 0) check("ack_spacing", k, 4);
        end
        req = '0;

        // Requester 2 drops req and changes inputs in SETUP; ptr is 1 here
        @(negedge clk);
        wdata[23:16] = 8'h5C; waddr[5:4] = 2'd1; req = 4'b0100;
        q0.push_back('{id: 2'd2, addr: 2'd1, data: 8'h5C});
        @(negedge clk);
        req = '0; wdata[23:16] = 8'hFF; waddr[5:4] = 2'd3;
        wait_ack(10, k);
        check("drop_ack", ack, 4'b0100);

        // Re-request after ack goes to lowest priority; ptr is 3 here
        @(negedge clk);
        wdata = 32'hD0_00_B0_00; waddr = 8'b01_00_10_00; req = 4'b1010;
        q0.push_back('{id: 2'd3, addr: 2'd1, data: 8'hD0});
        q0.push_back('{id: 2'd1, addr: 2'd2, data: 8'hB0});
        q0.push_back('{id: 2'd3, addr: 2'd1, data: 8'hD0});
        for (int i = 0; i < 3; i++) wait_ack(20, k);
        req = '0;

        // Reset during ENABLE, then full retry for requester 2
        @(negedge clk);
        wdata[23:16] = 8'h77; waddr[5:4] = 2'd0; req = 4'b0100;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (lat_en == 0 && waited < 10);
        check("reach_enable", lat_en, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_en", lat_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack", ack, 0);
        check("rst_mid_gnt", gnt_id, 0);
        q0.push_back('{id: 2'd2, addr: 2'd0, data: 8'h77});
        @(negedge clk);
        @(negedge clk); #2 rst = 1'b0;
        wait_ack(12, k);
        check("retry_ack", ack, 4'b0100);
        req = '0;

        // EN_CYC=3 instance: enable held exactly three cycles
        @(negedge clk);
        wdata3[15:8] = 8'h3C; waddr3[3:2] = 2'd3; req3 = 4'b0010;
        q1.push_back('{id: 2'd1, addr: 2'd3, data: 8'h3C});
        @(negedge clk);
        check("e3_setup_en", lat_en3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("e3_enable", lat_en3, 4'b1000);
        end
        @(negedge clk);
        check("e3_ack", ack3, 4'b0010);
        check("e3_hold_en", lat_en3, 0);
        check("e3_hold_d", lat_d3, 8'h3C);
        req3 = '0;

        repeat (4) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("final_busy", busy | busy3, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
